// File: rtl/demux_1to8_stream_pkg.sv
// Shared definitions for the 8-channel stream mux/demux pair: channel count,
// default widths, channel indices and the per-channel slot state encoding.
package demux_1to8_stream_pkg;

  localparam int NUM_CH     = 8;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_SWIDTH = 3;
  localparam int DEF_CWIDTH = 16;

  localparam int CH0 = 0;
  localparam int CH1 = 1;
  localparam int CH2 = 2;
  localparam int CH3 = 3;
  localparam int CH4 = 4;
  localparam int CH5 = 5;
  localparam int CH6 = 6;
  localparam int CH7 = 7;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_1to8_stream_chan_slot.sv
// One-entry holding register for a single demux channel, with an EMPTY/FULL FSM
// that supports drain-and-refill in the same cycle.
module demux_chan_slot
  import demux_1to8_stream_pkg::*;
#(
  parameter int width = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] d,
  input  logic             ready,
  output logic [width-1:0] q,
  output logic             valid
);

  slot_state_e      state_q, state_d;
  logic [width-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
          data_d  = d;
        end
      end
      SLOT_FULL: begin
        // A load while FULL only happens when the consumer drains this cycle.
        if (load) begin
          data_d = d;
        end else if (ready) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the data register is reset too because outputs must read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign q     = data_q;
  assign valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/demux_1to8_stream.sv
// Registered 1-to-8 stream demultiplexer: routes each accepted word to one of
// eight independently handshaken holding slots and counts accepted words.
module demux_1to8_stream
  import demux_1to8_stream_pkg::*;
#(
  parameter int width  = DEF_WIDTH,
  parameter int swidth = DEF_SWIDTH,
  parameter int cwidth = DEF_CWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [width-1:0]  in_data,
  input  logic [swidth-1:0] in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [width-1:0]  o0,
  output logic [width-1:0]  o1,
  output logic [width-1:0]  o2,
  output logic [width-1:0]  o3,
  output logic [width-1:0]  o4,
  output logic [width-1:0]  o5,
  output logic [width-1:0]  o6,
  output logic [width-1:0]  o7,
  output logic [NUM_CH-1:0] o_valid,
  input  logic [NUM_CH-1:0] o_ready,
  output logic [cwidth-1:0] xfer_cnt
);

  if (swidth != 3) begin : g_bad_swidth
    $error("demux_1to8_stream: swidth must be 3");
  end

  logic [NUM_CH-1:0] load;
  logic              accept;
  logic [cwidth-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [width-1:0]  slot_data [NUM_CH];

  // Timing path: in_ready is combinational from in_sel and o_ready, so a
  // downstream ready ripples straight to the upstream handshake in one cycle.
  assign in_ready = ~rst & (~o_valid[in_sel] | o_ready[in_sel]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    load       = '0;
    xfer_cnt_d = xfer_cnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      load[k] = accept && (in_sel == swidth'(k));
    end
    if (accept) begin
      xfer_cnt_d = xfer_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_chan_slot #(.width(width)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .d     (in_data),
      .ready (o_ready[k]),
      .q     (slot_data[k]),
      .valid (o_valid[k])
    );
  end

  assign o0       = slot_data[CH0];
  assign o1       = slot_data[CH1];
  assign o2       = slot_data[CH2];
  assign o3       = slot_data[CH3];
  assign o4       = slot_data[CH4];
  assign o5       = slot_data[CH5];
  assign o6       = slot_data[CH6];
  assign o7       = slot_data[CH7];
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_demux_1to8_stream.sv
// Directed self-checking bench for demux_1to8_stream (cwidth=4 so the
// transfer counter wrap is reachable in a short run).
module tb_demux_1to8_stream;

  localparam int W  = 4;
  localparam int SW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]    o_valid;
  logic [7:0]    o_ready;
  logic [CW-1:0] xfer_cnt;

  int checks   = 0;
  int failures = 0;

  demux_1to8_stream #(.width(W), .swidth(SW), .cwidth(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o4       (o4),
    .o5       (o5),
    .o6       (o6),
    .o7       (o7),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] chan_data(input int k);
    case (k)
      0: chan_data = o0;
      1: chan_data = o1;
      2: chan_data = o2;
      3: chan_data = o3;
      4: chan_data = o4;
      5: chan_data = o5;
      6: chan_data = o6;
      default: chan_data = o7;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sel   = 3'd2;
    in_data  = 4'hF;
    o_ready  = 8'h00;

    // Reset for two cycles with a word offered.
    #1;
    check("reset_in_ready_comb", {31'b0, in_ready}, 32'd0);
    tick();
    tick();
    check("reset_o_valid", {24'b0, o_valid}, 32'h00);
    check("reset_xfer_cnt", {28'b0, xfer_cnt}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("reset_o%0d", k), {28'b0, chan_data(k)}, 32'd0);
    end

    // Routing sweep: channels 0..7 get data 1..8 back to back.
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_sel   = SW'(k);
      in_data  = W'(k + 1);
      in_valid = 1'b1;
      #1;
      check($sformatf("sweep_in_ready_ch%0d", k), {31'b0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check("sweep_o_valid", {24'b0, o_valid}, 32'hFF);
    check("sweep_xfer_cnt", {28'b0, xfer_cnt}, 32'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("sweep_o%0d", k), {28'b0, chan_data(k)}, k + 1);
    end

    // Put 4'hA into ch3 via drain-and-refill.
    in_sel = 3'd3; in_data = 4'hA; in_valid = 1'b1; o_ready = 8'h08;
    tick();
    o_ready = 8'h00;
    check("ch3_load_a", {28'b0, o3}, 32'hA);
    check("ch3_load_cnt", {28'b0, xfer_cnt}, 32'd9);

    // Backpressure on ch3: word is refused, o3 holds.
    in_sel = 3'd3; in_data = 4'h5; in_valid = 1'b1;
    #1;
    check("bp_in_ready_ch3", {31'b0, in_ready}, 32'd0);
    tick();
    check("bp_o3_held", {28'b0, o3}, 32'hA);
    check("bp_cnt_held", {28'b0, xfer_cnt}, 32'd9);
    check("bp_o_valid", {24'b0, o_valid}, 32'hFF);

    // Drain ch6 alone; its data stays visible after going EMPTY.
    in_valid = 1'b0; o_ready = 8'h40;
    tick();
    o_ready = 8'h00;
    check("drain6_o_valid", {24'b0, o_valid}, 32'hBF);
    check("drain6_o6_kept", {28'b0, o6}, 32'h7);
    check("drain6_cnt", {28'b0, xfer_cnt}, 32'd9);

    // ch6 is EMPTY while ch3 is stalled: ch6 word is accepted at once.
    in_sel = 3'd6; in_data = 4'h5; in_valid = 1'b1;
    #1;
    check("bp_in_ready_ch6", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("ch6_o6", {28'b0, o6}, 32'h5);
    check("ch6_o3_isolated", {28'b0, o3}, 32'hA);
    check("ch6_o_valid", {24'b0, o_valid}, 32'hFF);
    check("ch6_cnt", {28'b0, xfer_cnt}, 32'd10);

    // ch2 gets 4'hC, then drain-and-refill with 4'h7.
    in_sel = 3'd2; in_data = 4'hC; in_valid = 1'b1; o_ready = 8'h04;
    tick();
    check("ch2_load_c", {28'b0, o2}, 32'hC);
    in_sel = 3'd2; in_data = 4'h7; in_valid = 1'b1; o_ready = 8'h04;
    #1;
    check("refill_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; o_ready = 8'h00;
    check("refill_o_valid", {24'b0, o_valid}, 32'hFF);
    check("refill_o2", {28'b0, o2}, 32'h7);
    check("refill_o1_isolated", {28'b0, o1}, 32'h2);
    check("refill_cnt", {28'b0, xfer_cnt}, 32'd12);

    // Wrap: reset, then 17 transfers through ch0 with its consumer always ready.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wrap_start_cnt", {28'b0, xfer_cnt}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      in_sel = 3'd0; in_data = W'(i + 1); in_valid = 1'b1; o_ready = 8'h01;
      tick();
      if (i == 15) check("wrap_cnt_16", {28'b0, xfer_cnt}, 32'd0);
    end
    in_valid = 1'b0; o_ready = 8'h00;
    check("wrap_cnt_17", {28'b0, xfer_cnt}, 32'd1);
    check("wrap_o0", {28'b0, o0}, 32'h1);
    check("wrap_o_valid", {24'b0, o_valid}, 32'h01);

    // Mid-reset with ch5 FULL: word is discarded and never presented.
    in_sel = 3'd5; in_data = 4'h9; in_valid = 1'b1;
    tick();
    check("mid_ch5_full", {24'b0, o_valid}, 32'h21);
    check("mid_o5", {28'b0, o5}, 32'h9);
    check("mid_cnt", {28'b0, xfer_cnt}, 32'd2);
    rst = 1'b1; in_data = 4'h3; in_valid = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("mid_rst_o_valid", {24'b0, o_valid}, 32'h00);
    check("mid_rst_o5", {28'b0, o5}, 32'h0);
    check("mid_rst_cnt", {28'b0, xfer_cnt}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; o_ready = 8'h20;
    tick();
    tick();
    check("post_rst_o_valid", {24'b0, o_valid}, 32'h00);
    check("post_rst_cnt", {28'b0, xfer_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
